multi_seq_div: RTL and testbench
================================

// Module: multi_seq_div
// PURPOSE
//  Sequential restoring unsigned divider; the inverse operation of the carry save multiplier family.
//  Computes quotient and remainder of dividend/divisor, one quotient bit per clock.
//  Uses a start/busy/done handshake. Sits beside the multipliers in the arithmetic library.
//  Intended check: feeding a multiplier product back with one factor returns the other factor.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  dividend     in   WIDTH  unsigned dividend, captured on accepted start
//  divisor      in   WIDTH  unsigned divisor, captured on accepted start
//  quotient     out  WIDTH  result quotient, registered, held until next accepted start
//  remainder    out  WIDTH  result remainder, registered, held until next accepted start
//  div_by_zero  out  1      set when the last accepted divisor was 0, held like results
//  busy         out  1      high in CALC state
//  done         out  1      one-cycle pulse in DONE state
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; quotient, remainder, div_by_zero, busy, done = 0.
//   Internal regs and counter = 0. A reset mid-CALC aborts the operation with no done pulse.
//  States and transitions:
//   IDLE -> CALC when start=1 and divisor!=0.
//   IDLE -> DONE when start=1 and divisor==0.
//   CALC -> DONE after WIDTH iterations.
//   DONE -> IDLE unconditionally, after 1 cycle.
//  Accepted start (IDLE, start=1) latches operands:
//   q_work=dividend, r_work=0 (WIDTH+1 bits), count=WIDTH-1, div_by_zero=0.
//  CALC, one iteration per edge:
//   t = {r_work[WIDTH-1:0], q_work[WIDTH-1]}.
//   If t >= {1'b0,divisor}: r_work = t-divisor and q_work = {q_work[WIDTH-2:0],1}.
//   Otherwise: r_work = t and q_work = {q_work[WIDTH-2:0],0}.
//   count decrements each edge. On the edge where count==0, state -> DONE.
//   On that same edge, quotient=q_work' and remainder=r_work'[WIDTH-1:0].
//  Latency: done is high in the cycle after the WIDTH-th edge following the start-sampling edge.
//   Divide by zero: done is high after 1 edge.
//  Divide by zero path, on the accepted start edge:
//   quotient = all ones, remainder = dividend, div_by_zero = 1.
//  busy=1 exactly in CALC. done=1 exactly in DONE. busy and done are never high together.
//  start is ignored in CALC and DONE: no restart, and latched operands are unaffected.
//   An earliest new start is accepted in the IDLE cycle after the done pulse.
//  Operand inputs may change freely after the accepting edge.
//  Results: quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
//  No overflow is possible: quotient <= dividend. Divisor 1 gives quotient=dividend, remainder=0.
// TESTING
//  1. WIDTH=4, dividend=13, divisor=3, start pulse
//     -> busy for 4 cycles, then done; quotient=4, remainder=1, div_by_zero=0.
//  2. WIDTH=4, cases 15/1 -> q=15 r=0; 7/9 -> q=0 r=7; 0/5 -> q=0 r=0; 15/15 -> q=1 r=0.
//  3. WIDTH=4, dividend=11, divisor=0
//     -> done one edge after start; quotient=15, remainder=11, div_by_zero=1, busy never high.
//  4. Start 13/3, then assert start with 2/1 on the second CALC cycle
//     -> ignored; result still q=4 r=1, exactly one done pulse.
//  5. Start 9/2, assert rst asynchronously mid-CALC
//     -> all outputs 0 immediately, state IDLE, no done. A following 9/2 gives q=4 r=1.
//  6. WIDTH=8, 255/16 -> q=15 r=15 after 8 cycles. Then an exhaustive sweep:
//     all dividend/divisor pairs, back-to-back starts, each checked against a reference model.

Source files
------------

// File: rtl/multi_seq_div_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives the request and operands; the slave returns results and status.
interface multi_seq_div_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, div_by_zero, busy, done
    );
endinterface

// File: rtl/multi_seq_div.sv
// Sequential restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor skips the iterations and reports all-ones quotient with the dividend as remainder.
module multi_seq_div #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    multi_seq_div_if.slave     bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_work_q, q_work_d;
    logic [WIDTH:0]   r_work_q, r_work_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_work_q    <= '0;
            r_work_q    <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_work_q    <= q_work_d;
            r_work_q    <= r_work_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial = {r_work_q[WIDTH-1:0], q_work_q[WIDTH-1]};
        if (trial >= {1'b0, divisor_q}) begin
            r_next = trial - {1'b0, divisor_q};
            q_next = {q_work_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = trial;
            q_next = {q_work_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        q_work_d    = q_work_q;
        r_work_d    = r_work_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_work_d  = bus.dividend;
                    r_work_d  = '0;
                    divisor_d = bus.divisor;
                    count_d   = CW'(WIDTH - 1);
                    dbz_d     = 1'b0;
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                q_work_d = q_next;
                r_work_d = r_next;
                count_d  = count_q - CW'(1);
                if (count_q == '0) begin
                    quotient_d  = q_next;
                    remainder_d = r_next[WIDTH-1:0];
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_multi_seq_div.sv
// Directed bench for the sequential divider at WIDTH=4 and WIDTH=8,
// plus a full 4-bit operand sweep against an arithmetic reference.
module tb_multi_seq_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multi_seq_div_if #(.WIDTH(4)) bus4 ();
    multi_seq_div_if #(.WIDTH(8)) bus8 ();

    multi_seq_div #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    multi_seq_div #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Launch one 4-bit division; returns at the negedge where done is seen.
    // edges counts clock edges from the accepting edge up to and including the one that enters DONE.
    task automatic div4(input int dd, input int dv, output int edges, output int busy_cycles);
        @(negedge clk);
        bus4.dividend = 4'(dd);
        bus4.divisor  = 4'(dv);
        bus4.start    = 1'b1;
        @(negedge clk);
        bus4.start  = 1'b0;
        bus4.dividend = 4'(~dd);
        bus4.divisor  = 4'(~dv);
        edges       = 1;
        busy_cycles = 0;
        while (!bus4.done && edges < 20) begin
            if (bus4.busy) busy_cycles++;
            check("busy_done_excl", 32'(bus4.busy & bus4.done), 32'd0);
            @(negedge clk);
            edges++;
        end
        check("done_seen4", 32'(bus4.done), 32'd1);
    endtask

    task automatic div8(input int dd, input int dv, output int edges);
        @(negedge clk);
        bus8.dividend = 8'(dd);
        bus8.divisor  = 8'(dv);
        bus8.start    = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        edges      = 1;
        while (!bus8.done && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check("done_seen8", 32'(bus8.done), 32'd1);
    endtask

    initial begin
        int edges, bc, pulses;
        int d4 [4]  = '{15, 7, 0, 15};
        int v4 [4]  = '{1, 9, 5, 15};
        int q4 [4]  = '{15, 0, 0, 1};
        int r4 [4]  = '{0, 7, 0, 0};
        int d8 [6]  = '{255, 200, 100, 255, 1, 128};
        int v8 [6]  = '{16, 7, 0, 1, 255, 128};
        int q8 [6]  = '{15, 28, 255, 255, 0, 1};
        int r8 [6]  = '{15, 4, 100, 0, 1, 0};
        int z8 [6]  = '{0, 0, 1, 0, 0, 0};
        int e8 [6]  = '{9, 9, 1, 9, 9, 9};

        bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        #12;
        check("rst_quot", 32'(bus4.quotient), 32'd0);
        check("rst_rem", 32'(bus4.remainder), 32'd0);
        check("rst_dbz", 32'(bus4.div_by_zero), 32'd0);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_done", 32'(bus4.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 13/3: four busy cycles, done on the fifth edge
        div4(13, 3, edges, bc);
        check("t1_edges", 32'(edges), 32'd5);
        check("t1_busy", 32'(bc), 32'd4);
        check("t1_quot", 32'(bus4.quotient), 32'd4);
        check("t1_rem", 32'(bus4.remainder), 32'd1);
        check("t1_dbz", 32'(bus4.div_by_zero), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus4.done), 32'd0);
        check("t1_held_quot", 32'(bus4.quotient), 32'd4);

        for (int i = 0; i < 4; i++) begin
            div4(d4[i], v4[i], edges, bc);
            check($sformatf("t2_quot_%0d_%0d", d4[i], v4[i]), 32'(bus4.quotient), 32'(q4[i]));
            check($sformatf("t2_rem_%0d_%0d", d4[i], v4[i]), 32'(bus4.remainder), 32'(r4[i]));
        end

        div4(11, 0, edges, bc);
        check("t3_edges", 32'(edges), 32'd1);
        check("t3_busy", 32'(bc), 32'd0);
        check("t3_quot", 32'(bus4.quotient), 32'd15);
        check("t3_rem", 32'(bus4.remainder), 32'd11);
        check("t3_dbz", 32'(bus4.div_by_zero), 32'd1);

        // start re-asserted during CALC must not restart or disturb the operation
        @(negedge clk);
        bus4.dividend = 4'd13; bus4.divisor = 4'd3; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.dividend = 4'd2; bus4.divisor = 4'd1; bus4.start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus4.done) begin
                pulses++;
                check("t4_quot", 32'(bus4.quotient), 32'd4);
                check("t4_rem", 32'(bus4.remainder), 32'd1);
                bus4.start = 1'b0;
            end
            @(negedge clk);
        end
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_held_rem", 32'(bus4.remainder), 32'd1);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus4.dividend = 4'd9; bus4.divisor = 4'd2; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_quot", 32'(bus4.quotient), 32'd0);
        check("t5_rem", 32'(bus4.remainder), 32'd0);
        check("t5_busy", 32'(bus4.busy), 32'd0);
        check("t5_done", 32'(bus4.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(bus4.done);
            @(negedge clk);
        end
        check("t5_no_done", 32'(pulses), 32'd0);
        div4(9, 2, edges, bc);
        check("t5_quot_after", 32'(bus4.quotient), 32'd4);
        check("t5_rem_after", 32'(bus4.remainder), 32'd1);

        for (int i = 0; i < 6; i++) begin
            div8(d8[i], v8[i], edges);
            check($sformatf("t6_edges_%0d_%0d", d8[i], v8[i]), 32'(edges), 32'(e8[i]));
            check($sformatf("t6_quot_%0d_%0d", d8[i], v8[i]), 32'(bus8.quotient), 32'(q8[i]));
            check($sformatf("t6_rem_%0d_%0d", d8[i], v8[i]), 32'(bus8.remainder), 32'(r8[i]));
            check($sformatf("t6_dbz_%0d_%0d", d8[i], v8[i]), 32'(bus8.div_by_zero), 32'(z8[i]));
        end

        // every 4-bit pair, back-to-back starts
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                div4(dd, dv, edges, bc);
                check($sformatf("sw_quot_%0d_%0d", dd, dv), 32'(bus4.quotient),
                      (dv == 0) ? 32'd15 : 32'(dd / dv));
                check($sformatf("sw_rem_%0d_%0d", dd, dv), 32'(bus4.remainder),
                      (dv == 0) ? 32'(dd) : 32'(dd % dv));
                check($sformatf("sw_dbz_%0d_%0d", dd, dv), 32'(bus4.div_by_zero),
                      (dv == 0) ? 32'd1 : 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
